wb_axi_stream_bridge: RTL and testbench

- Wishbone slave that terminates CPU accesses into the user-project window and converts them into AXI-Lite master transactions (config/tap space) or AXI-Stream master/slave beats (sample in, result out) toward the accelerator core.
- Parametrised successor of the single-mode bridge: configurable address window, data width and stream offsets, plus a decoupled AW/W handshake, automatic ss_tlast generation from a snooped length register, and bounded response latency.

---
 rtl/wb_axi_stream_bridge.sv | 167 ++++++++++++++++
 tb/tb_wb_axi_stream_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi_stream_bridge.sv
// wb_axi_stream_bridge: Wishbone slave window bridged to an AXI-Lite master (config/tap space)
// and an AXI-Stream master/slave pair (sample push at SS_OFFSET, result pop at SM_OFFSET).
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wbs_*                         Wishbone slave (sel ignored, full-word accesses only)
//   aw*/w*/ar*/r*                 AXI-Lite master toward the accelerator registers
//   ss_*                          AXI-Stream master (one beat per write to SS_OFFSET)
//   sm_*                          AXI-Stream slave (one beat per read of SM_OFFSET)
//   busy                          transaction in flight
// Optional: define TIMEOUT_EN to bound every handshake wait to TIMEOUT cycles; a timed-out
// access is acknowledged (reads return 32'hDEAD_BEEF) and sets a sticky error bit read back
// (and cleared) at window offset 0xFFC.
module wb_axi_stream_bridge #(
    parameter logic [31:0]            BASE_ADDR   = 32'h3000_0000,
    parameter int                     pADDR_WIDTH = 12,
    parameter int                     pDATA_WIDTH = 32,
    parameter logic [pADDR_WIDTH-1:0] SS_OFFSET   = 'h080,
    parameter logic [pADDR_WIDTH-1:0] SM_OFFSET   = 'h084,
    parameter logic [pADDR_WIDTH-1:0] LEN_OFFSET  = 'h010,
    parameter int                     TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ss_tvalid,
    output logic                   ss_tlast,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic                   sm_tlast,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tready,
    output logic                   busy
);
    typedef enum logic [2:0] {IDLE, LITE_WR, LITE_RD_A, LITE_RD_D, SS_PUSH, SM_POP, ACK} state_t;

    state_t                 state, state_n;
    logic [pADDR_WIDTH-1:0] off, addr_q;
    logic [pDATA_WIDTH-1:0] wdata_q, data_length, beat_cnt, eff_len;
    logic [31:0]            dat_q;
    logic                   aw_done, w_done, last_q;
    logic                   hit, aw_hs, w_hs, adv, to, tmo, st_rd, err_rd;
    logic                   unused_ok;

    assign off       = wbs_adr_i[pADDR_WIDTH-1:0];
    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:pADDR_WIDTH] == BASE_ADDR[31:pADDR_WIDTH]);
    // A zero length would never produce tlast; treat it as single-beat frames.
    assign eff_len   = (data_length == '0) ? pDATA_WIDTH'(1) : data_length;
    assign unused_ok = &{1'b0, wbs_sel_i, sm_tlast, wbs_dat_i};

    // Handshake outputs decode straight from registered state, so reset drops them on the next edge.
    assign awvalid   = (state == LITE_WR) & ~aw_done;
    assign wvalid    = (state == LITE_WR) & ~w_done;
    assign arvalid   = (state == LITE_RD_A);
    assign rready    = (state == LITE_RD_D);
    assign ss_tvalid = (state == SS_PUSH);
    assign sm_tready = (state == SM_POP);
    assign wbs_ack_o = (state == ACK);
    assign wbs_dat_o = wbs_ack_o ? dat_q : '0;
    assign busy      = (state != IDLE);
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign ss_tdata  = wdata_q;
    assign ss_tlast  = last_q;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;

`ifdef TIMEOUT_EN
    localparam logic [pADDR_WIDTH-1:0] ST_OFFSET = {{(pADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [31:0] tcnt;
    logic        err;

    assign st_rd  = ~wbs_we_i & (off == ST_OFFSET);
    assign err_rd = err;
    assign tmo    = busy & (state != ACK) & (tcnt == 32'(TIMEOUT - 1));

    // Counter restarts on every state change, so each handshake gets its own budget.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= (busy && state_n == state) ? tcnt + 32'd1 : '0;
            err  <= to | (err & ~(state == IDLE && hit && st_rd));
        end
    end
`else
    assign st_rd  = 1'b0;
    assign err_rd = 1'b0;
    assign tmo    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        adv     = 1'b0;
        case (state)
            IDLE:      state_n = !hit ? IDLE
                               : wbs_we_i ? ((off == SS_OFFSET) ? SS_PUSH : LITE_WR)
                               : (off == SM_OFFSET) ? SM_POP
                               : st_rd ? ACK : LITE_RD_A;
            LITE_WR:   adv = (aw_done | aw_hs) & (w_done | w_hs);
            LITE_RD_A: adv = arready;
            LITE_RD_D: adv = rvalid;
            SS_PUSH:   adv = ss_tready;
            SM_POP:    adv = sm_tvalid;
            ACK:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        // A handshake landing on the timeout cycle still completes normally.
        to = tmo & ~adv;
        if (adv | to) state_n = (state == LITE_RD_A && !to) ? LITE_RD_D : ACK;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            dat_q       <= '0;
            data_length <= '0;
            beat_cnt    <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && hit) begin
                addr_q  <= off;
                wdata_q <= wbs_dat_i[pDATA_WIDTH-1:0];
                dat_q   <= {31'b0, err_rd & st_rd};
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                last_q  <= beat_cnt >= eff_len - pDATA_WIDTH'(1);
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) begin
                w_done <= 1'b1;
                if (addr_q == LEN_OFFSET) data_length <= wdata_q;
            end
            if (state == LITE_RD_D && rvalid) dat_q <= 32'(rdata);
            if (state == SM_POP && sm_tvalid) dat_q <= 32'(sm_tdata);
            if (ss_tvalid && ss_tready) beat_cnt <= last_q ? '0 : beat_cnt + pDATA_WIDTH'(1);
            if (to && (state == LITE_RD_A || state == LITE_RD_D || state == SM_POP)) dat_q <= 32'hDEAD_BEEF;
        end
    end
endmodule

// File: tb/tb_wb_axi_stream_bridge.sv
// tb_wb_axi_stream_bridge: directed and randomized checks of the Wishbone to AXI-Lite/AXI-Stream bridge
module tb_wb_axi_stream_bridge;
    logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata = '0, ss_tdata, sm_tdata = '0;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic        ss_tvalid, ss_tlast, ss_tready = 1'b0;
    logic        sm_tvalid = 1'b0, sm_tlast = 1'b0, sm_tready, busy;

    wb_axi_stream_bridge #(.TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tdata(sm_tdata), .sm_tready(sm_tready),
        .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0, n_bad = 0;
    int aw_dly, w_dly, ar_dly, r_dly, ss_dly, sm_dly;
    logic [31:0] rsp;
    int o_ack, o_lat, o_awc, o_wc, o_arc, o_rrc, o_ssc, o_smc, o_pay_bad, o_axi;
    logic [31:0] o_dat;
    logic o_last;
    int model_len = 0, push_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Expected tlast of the next push: frames of max(len,1) beats.
    function automatic logic next_last();
        int l = (model_len == 0) ? 1 : model_len;
        next_last = (push_n % l) == l - 1;
        push_n++;
    endfunction

    // One Wishbone access; the bench acts as AXI-Lite slave and stream peer using the *_dly settings.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input int budget);
        logic [31:0] eoff;
        bit done;
        int post;
        eoff = 32'(adr[11:0]);
        done = 0; post = 0;
        o_ack = 0; o_lat = 1; o_awc = 0; o_wc = 0; o_arc = 0; o_rrc = 0; o_ssc = 0; o_smc = 0;
        o_pay_bad = 0; o_axi = 0; o_dat = '0; o_last = 1'b0;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
        for (int c = 0; c < budget; c++) begin
            @(negedge wb_clk_i);
            if (done) post++;
            if (post > 3) break;
            if (!done) o_lat++;
            if (wbs_ack_o) begin
                o_ack++;
                if (!done) o_dat = wbs_dat_o;
                done = 1;
                wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
            end else if (wbs_dat_o !== '0) o_pay_bad++;
            o_axi += int'(awvalid | wvalid | arvalid | rready | ss_tvalid | sm_tready);
            awready = awvalid && o_awc >= aw_dly;
            if (awvalid) begin o_awc++; if (awaddr !== eoff[11:0]) o_pay_bad++; end
            wready = wvalid && o_wc >= w_dly;
            if (wvalid) begin o_wc++; if (wdata !== dat) o_pay_bad++; end
            arready = arvalid && o_arc >= ar_dly;
            if (arvalid) begin o_arc++; if (araddr !== eoff[11:0]) o_pay_bad++; end
            rvalid = rready && o_rrc >= r_dly;
            rdata = rvalid ? rsp : '0;
            if (rready) o_rrc++;
            ss_tready = ss_tvalid && o_ssc >= ss_dly;
            if (ss_tvalid) begin o_ssc++; o_last = ss_tlast; if (ss_tdata !== dat) o_pay_bad++; end
            sm_tvalid = sm_tready && o_smc >= sm_dly;
            sm_tdata = sm_tvalid ? rsp : '0;
            if (sm_tready) o_smc++;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        {awready, wready, arready, rvalid, ss_tready, sm_tvalid} = '0;
    endtask

    task automatic expect_done(input string tag, input logic [31:0] dat);
        check({tag, "_ack"}, o_ack, 1);
        check({tag, "_dat"}, o_dat, dat);
        check({tag, "_payload"}, o_pay_bad, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [6:0] lasts;
        logic [31:0] d, a;
        int kind;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; ss_dly = 0; sm_dly = 0; rsp = '0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_ctrl", {wbs_ack_o, busy, awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready}, 0);
        check("rst_dat_o", wbs_dat_o, 0);
        check("rst_addr", {awaddr, araddr}, 0);
        check("rst_wdata", wdata, 0);
        check("rst_ss_tdata", ss_tdata, 0);
        wb_rst_i = 1'b0;

        // Length register write with awready two cycles late.
        aw_dly = 2; w_dly = 0;
        xfer(1'b1, 32'h3000_0010, 32'h40, 40);
        model_len = 64;
        expect_done("len_wr", 0);
        check("len_wr_awcycles", o_awc, 3);
        check("len_wr_wcycles", o_wc, 1);

        aw_dly = 0;
        xfer(1'b1, 32'h3000_0100, 32'hCAFE_0001, 40);
        expect_done("fast_wr", 0);
        check("fast_wr_latency", o_lat, 3);

        ar_dly = 0; r_dly = 4; rsp = 32'h1234;
        xfer(1'b0, 32'h3000_0020, 0, 40);
        expect_done("lite_rd", 32'h0000_1234);
        check("lite_rd_rready_cycles", o_rrc, 5);

        // Three-beat frames: tlast on beats 3 and 6.
        xfer(1'b1, 32'h3000_0010, 32'd3, 40);
        model_len = 3;
        expect_done("len3_wr", 0);
        lasts = '0;
        for (int i = 0; i < 7; i++) begin
            ss_dly = i % 2;
            d = $urandom;
            xfer(1'b1, 32'h3000_0080, d, 40);
            lasts[i] = o_last;
            check($sformatf("push%0d_last", i), o_last, next_last());
            expect_done($sformatf("push%0d", i), 0);
        end
        check("push_tlast_pattern", lasts, 7'b010_0100);

        sm_dly = 5; rsp = 32'hABCD;
        xfer(1'b0, 32'h3000_0084, 0, 40);
        expect_done("sm_pop", 32'h0000_ABCD);
        check("sm_pop_tready_cycles", o_smc, 6);

        xfer(1'b0, 32'h2600_000C, 0, 8);
        check("miss_ack", o_ack, 0);
        check("miss_axi", o_axi, 0);
        xfer(1'b1, 32'h3000_1080, 32'h5, 8);
        check("miss_edge_ack", o_ack, 0);
        check("miss_edge_axi", o_axi, 0);

        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
            ss_dly = $urandom_range(0, 4); sm_dly = $urandom_range(0, 4);
            rsp = $urandom; d = $urandom;
            a = 32'h3000_0000 | 32'($urandom_range(64, 1021) * 4);
            case (kind)
                0: begin
                    xfer(1'b1, a, d, 40);
                    expect_done($sformatf("rnd%0d_wr", i), 0);
                    check($sformatf("rnd%0d_wr_cycles", i), {o_awc[15:0], o_wc[15:0]}, {16'(aw_dly + 1), 16'(w_dly + 1)});
                end
                1: begin
                    xfer(1'b0, a, 0, 40);
                    expect_done($sformatf("rnd%0d_rd", i), rsp);
                    check($sformatf("rnd%0d_rd_cycles", i), {o_arc[15:0], o_rrc[15:0]}, {16'(ar_dly + 1), 16'(r_dly + 1)});
                end
                2: begin
                    xfer(1'b1, 32'h3000_0080, d, 40);
                    expect_done($sformatf("rnd%0d_push", i), 0);
                    check($sformatf("rnd%0d_push_last", i), o_last, next_last());
                    check($sformatf("rnd%0d_push_cycles", i), o_ssc, ss_dly + 1);
                end
                default: begin
                    xfer(1'b0, 32'h3000_0084, 0, 40);
                    expect_done($sformatf("rnd%0d_pop", i), rsp);
                    check($sformatf("rnd%0d_pop_cycles", i), o_smc, sm_dly + 1);
                end
            endcase
        end

`ifdef TIMEOUT_EN
        ss_dly = 1000;
        xfer(1'b1, 32'h3000_0080, 32'h77, 40);
        expect_done("to_push", 0);
        check("to_push_wait", o_ssc, 8);
        xfer(1'b0, 32'h3000_0FFC, 0, 40);
        expect_done("to_status1", 1);
        check("to_status_axi", o_axi, 0);
        xfer(1'b0, 32'h3000_0FFC, 0, 40);
        expect_done("to_status0", 0);
        sm_dly = 1000;
        xfer(1'b0, 32'h3000_0084, 0, 40);
        expect_done("to_pop", 32'hDEAD_BEEF);
        xfer(1'b0, 32'h3000_0FFC, 0, 40);
        expect_done("to_status2", 1);
`endif

        // Reset while a push is stalled.
        ss_dly = 1000;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h3000_0080; wbs_dat_i = 32'h99;
        repeat (2) @(negedge wb_clk_i);
        check("rst_mid_tvalid_before", ss_tvalid, 1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rst_mid_tvalid", ss_tvalid, 0);
        check("rst_mid_ack_busy", {wbs_ack_o, busy}, 0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_len = 0; push_n = 0;
        ss_dly = 0;
        for (int i = 0; i < 2; i++) begin
            xfer(1'b1, 32'h3000_0080, 32'(i), 40);
            expect_done($sformatf("len0_push%0d", i), 0);
            check($sformatf("len0_push%0d_last", i), o_last, next_last());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
